vga_sync_gen: RTL and testbench

- Raster timing generator for the TinyQV VGA peripheral at 1024x768@60 on the 64 MHz project clock.
- Maintains the horizontal and vertical beam counters.
- Decodes sync, blank and new-scanline strobes, and raises the peripheral's user interrupt on programmable hblank/vblank events.
- Sits directly upstream of the VRAM scan-out/colour stage, which consumes x, y, blank, retrace, hsync and vsync.

---
 rtl/vga_sync_if.sv | 27 ++
 rtl/vga_sync_gen.sv | 67 ++++++
 tb/tb_vga_sync_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Control and raster-timing signals between the TinyQV VGA register block
// and the sync generator.
interface vga_sync_if;
    logic        cli;
    logic        enable_interrupt_on_hblank;
    logic        enable_interrupt_on_vblank;
    logic        narrow_960;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hsync;
    logic        vsync;
    logic        retrace;
    logic        blank;
    logic        interrupt;

    // Host side: drives the interrupt controls and consumes the raster timing.
    modport master (
        output cli, enable_interrupt_on_hblank, enable_interrupt_on_vblank, narrow_960,
        input  x, y, hsync, vsync, retrace, blank, interrupt
    );

    // Generator side.
    modport slave (
        input  cli, enable_interrupt_on_hblank, enable_interrupt_on_vblank, narrow_960,
        output x, y, hsync, vsync, retrace, blank, interrupt
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: beam counters, sync/blank/retrace decodes and the
// sticky hblank/vblank user interrupt.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 1024,
    parameter int unsigned H_FRONT   = 24,
    parameter int unsigned H_SYNC    = 136,
    parameter int unsigned H_BACK    = 160,
    parameter int unsigned H_NARROW  = 960,
    parameter int unsigned V_VISIBLE = 768,
    parameter int unsigned V_FRONT   = 3,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 29
) (
    input logic        clk,
    input logic        rst,
    vga_sync_if.slave  bus
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS0     = H_VISIBLE + H_FRONT;
    localparam int unsigned VS0     = V_VISIBLE + V_FRONT;

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        irq_q, irq_d;
    logic [10:0] active_w;
    logic        line_end;
    logic        hblank_evt;
    logic        vblank_evt;

    always_comb begin
        active_w   = bus.narrow_960 ? 11'(H_NARROW) : 11'(H_VISIBLE);
        line_end   = (x_q == 11'(H_TOTAL - 1));
        x_d        = line_end ? 11'd0 : x_q + 11'd1;
        y_d        = y_q;
        if (line_end) begin
            y_d = (y_q == 10'(V_TOTAL - 1)) ? 10'd0 : y_q + 10'd1;
        end
        hblank_evt = bus.enable_interrupt_on_hblank && (x_q == active_w) &&
                     (y_q < 10'(V_VISIBLE));
        vblank_evt = bus.enable_interrupt_on_vblank && (x_q == 11'd0) &&
                     (y_q == 10'(V_VISIBLE));
        // A new event outranks a simultaneous clear.
        irq_d      = (irq_q && !bus.cli) || hblank_evt || vblank_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            irq_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            irq_q <= irq_d;
        end
    end

    // Decodes are combinational so they line up with x/y with no extra latency.
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.blank     = (x_q >= active_w) || (y_q >= 10'(V_VISIBLE));
    assign bus.hsync     = !((x_q >= 11'(HS0)) && (x_q < 11'(HS0 + H_SYNC)));
    assign bus.vsync     = !((y_q >= 10'(VS0)) && (y_q < 10'(VS0 + V_SYNC)));
    assign bus.retrace   = (x_q == 11'(HS0));
    assign bus.interrupt = irq_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: per-cycle scoreboard against a beam model, a table
// of decode vectors on one line, and interrupt/reset sequences.
module tb_vga_sync_gen;
    localparam int VV = 8;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 2;
    localparam int VT = VV + VF + VS + VB;
    localparam int HT = 1344;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_if bus();

    vga_sync_gen #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int x;
        int y;
        bit irq;
    } exp_t;

    typedef struct {
        bit narrow;
        int x;
        bit blank;
        bit hsync;
        bit retrace;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   checks = 0;
    int   errors = 0;
    int   mx = 0;
    int   my = 0;
    bit   mirq = 1'b0;
    bit   stat_en = 1'b0;
    bit   prev_irq = 1'b0;
    int   hs_low, rt_cnt, rt_x, vs_low, blank_miss, rises;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_blank(input int x, input int y, input bit n);
        return (x >= (n ? 960 : 1024)) || (y >= VV);
    endfunction

    function automatic bit m_hsync(input int x);
        return !(x >= 1048 && x <= 1183);
    endfunction

    function automatic bit m_vsync(input int y);
        return !(y >= VV + VF && y < VV + VF + VS);
    endfunction

    task automatic tick();
        exp_t e;
        bit   ev;
        @(posedge clk);
        if (rst) begin
            mx = 0; my = 0; mirq = 1'b0;
        end else begin
            ev = (bus.enable_interrupt_on_hblank && mx == (bus.narrow_960 ? 960 : 1024) && my < VV) ||
                 (bus.enable_interrupt_on_vblank && mx == 0 && my == VV);
            mirq = (mirq && !bus.cli) || ev;
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        sb.push_back('{mx, my, mirq});
        @(negedge clk);
        e = sb.pop_front();
        chk("sb_x", bus.x, e.x);
        chk("sb_y", bus.y, e.y);
        chk("sb_irq", bus.interrupt, e.irq);
        chk("sb_blank", bus.blank, m_blank(e.x, e.y, bus.narrow_960));
        chk("sb_hsync", bus.hsync, m_hsync(e.x));
        chk("sb_vsync", bus.vsync, m_vsync(e.y));
        chk("sb_retrace", bus.retrace, e.x == 1048);
        if (stat_en) begin
            if (my == 0 && !bus.hsync) hs_low++;
            if (my == 0 && bus.retrace) begin rt_cnt++; rt_x = bus.x; end
            if (!bus.vsync) vs_low++;
            if (my >= VV && !bus.blank) blank_miss++;
        end
        if (bus.interrupt && !prev_irq) rises++;
        prev_irq = bus.interrupt;
    endtask

    task automatic run_to(input int tx, input int ty);
        int n = 0;
        while (!(mx == tx && my == ty)) begin
            if (n >= 30000) begin
                chk("run_to_budget", 0, 1);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"}, bus.x, 0);
        chk({tag, "_y"}, bus.y, 0);
        chk({tag, "_irq"}, bus.interrupt, 0);
        chk({tag, "_hsync"}, bus.hsync, 1);
        chk({tag, "_vsync"}, bus.vsync, 1);
        chk({tag, "_blank"}, bus.blank, 0);
        chk({tag, "_retrace"}, bus.retrace, 0);
    endtask

    task automatic pulse_cli();
        bus.cli = 1'b1;
        tick();
        bus.cli = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0,  959, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1,  959, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1,  960, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0,  960, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1023, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1024, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1047, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1048, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1048, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1183, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1184, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1343, 1'b1, 1'b1, 1'b0};

        bus.cli = 1'b0;
        bus.enable_interrupt_on_hblank = 1'b0;
        bus.enable_interrupt_on_vblank = 1'b0;
        bus.narrow_960 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;

        // One line, then the rest of the frame.
        hs_low = 0; rt_cnt = 0; rt_x = -1; vs_low = 0; blank_miss = 0;
        stat_en = 1'b1;
        repeat (HT) tick();
        chk("line_wrap_x", bus.x, 0);
        chk("line_wrap_y", bus.y, 1);
        chk("hsync_low_clocks", hs_low, 136);
        chk("retrace_count", rt_cnt, 1);
        chk("retrace_x", rt_x, 1048);
        repeat (HT * VT - HT) tick();
        stat_en = 1'b0;
        chk("frame_wrap_x", bus.x, 0);
        chk("frame_wrap_y", bus.y, 0);
        chk("vsync_low_clocks", vs_low, VS * HT);
        chk("vblank_blank_miss", blank_miss, 0);

        // Decode vectors on line 5, toggling narrow_960 mid-line.
        for (int i = 0; i < 12; i++) begin
            run_to(tbl[i].x, 5);
            bus.narrow_960 = tbl[i].narrow;
            #1;
            chk($sformatf("vec%0d_blank", i), bus.blank, tbl[i].blank);
            chk($sformatf("vec%0d_hsync", i), bus.hsync, tbl[i].hsync);
            chk($sformatf("vec%0d_retrace", i), bus.retrace, tbl[i].retrace);
        end

        // Hblank interrupt.
        bus.narrow_960 = 1'b0;
        bus.enable_interrupt_on_hblank = 1'b1;
        do_reset();
        run_to(1024, 0);
        chk("hb_before_evt", bus.interrupt, 0);
        tick();
        chk("hb_rise_y0", bus.interrupt, 1);
        run_to(1100, 0);
        chk("hb_sticky", bus.interrupt, 1);
        pulse_cli();
        chk("hb_cleared", bus.interrupt, 0);
        run_to(1024, 1);
        chk("hb_before_y1", bus.interrupt, 0);
        tick();
        chk("hb_rise_y1", bus.interrupt, 1);

        // Mid-frame reset with an interrupt pending.
        run_to(500, 2);
        chk("irq_pending_pre_rst", bus.interrupt, 1);
        do_reset();
        chk_reset_state("midrst");

        for (int l = 0; l < VV; l++) begin
            run_to(1100, l);
            pulse_cli();
        end
        run_to(1025, VV);
        chk("hb_no_rise_vblank_a", bus.interrupt, 0);
        run_to(1025, VV + 3);
        chk("hb_no_rise_vblank_b", bus.interrupt, 0);

        // Vblank interrupt, once per frame, winning over a coincident cli.
        bus.enable_interrupt_on_hblank = 1'b0;
        bus.enable_interrupt_on_vblank = 1'b1;
        do_reset();
        rises = 0;
        run_to(0, VV);
        chk("vb_before_evt", bus.interrupt, 0);
        pulse_cli();
        chk("vb_evt_beats_cli", bus.interrupt, 1);
        run_to(0, VV + 1);
        chk("vb_sticky", bus.interrupt, 1);
        pulse_cli();
        chk("vb_cleared", bus.interrupt, 0);
        run_to(HT - 1, VT - 1);
        tick();
        chk("vb_rises_per_frame", rises, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
